mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Moore FSM sequencing the repeated-addition multiplier datapath: operand register A, down-counting register B (load/decrement), product accumulator P, zero comparator on B.
- Issues load, clear and decrement strobes to the datapath and counts iterations.
- Provides a start/done/ack handshake to the host and a watchdog error for a stuck counter.

Parameters:
- ITER_W, 16, width of the iteration counter; matches the datapath word width.
- MAX_ITER, 16'hFFFF, iteration limit; reaching it without eqz raises err.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  host request; sampled only in IDLE.
- ack  input  1  host acknowledge of done/err; sampled only in DONE/ERR.
- eqz  input  1  from datapath; 1 when the B counter value is zero.
- lda  output  1  load operand A.
- ldb  output  1  load counter B (drives the B register load input).
- clrp  output  1  clear product P.
- ldp  output  1  load P with P+A.
- decb  output  1  decrement counter B.
- busy  output  1  operation in progress.
- done  output  1  result valid in P.
- err  output  1  watchdog abort.
- iter_cnt  output  ITER_W  number of ADD cycles in the current/last operation.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset, async at any time including mid-operation:
  - state is IDLE; iter_cnt is 0; all strobes, busy, done and err are 0.
  - No strobe glitches out during reset.
- All outputs decode from the state register only (Moore). Strobes are single-cycle pulses.
- States and transitions:
  - IDLE: all outputs 0. start=1 → LOAD_A.
  - LOAD_A: lda=1, clrp=1, busy=1; iter_cnt is cleared to 0 at this edge. → LOAD_B.
  - LOAD_B: ldb=1, busy=1. → CHECK.
  - CHECK: busy=1, no strobes. Evaluated in this priority order:
    - eqz=1 → DONE.
    - else iter_cnt==MAX_ITER → ERR.
    - else → ADD.
  - ADD: ldp=1, decb=1, busy=1; iter_cnt increments at the exit edge. → CHECK.
  - DONE: done=1, busy=0; held indefinitely. ack=1 → IDLE.
  - ERR: err=1, done=1, busy=0; held. ack=1 → IDLE.
- Latency: start sampled at edge 0; counter loaded with n, no watchdog hit.
  - LOAD_A during cycle 1, LOAD_B cycle 2, first CHECK cycle 3.
  - Then n ADD/CHECK pairs; done first high in cycle 4+2n.
  - n=0: done high in cycle 4; ldp never pulses; P stays cleared.
- iter_cnt:
  - Holds its final value through DONE/ERR and IDLE until the next LOAD_A.
  - Never exceeds MAX_ITER; the ERR exit prevents further increments.
- start is ignored in every state except IDLE; holding start high does not retrigger until the FSM returns to IDLE.
- ack is ignored outside DONE/ERR.
  - start and ack both high in DONE: → IDLE only; the new start is taken the following cycle if still high.
- eqz is ignored in every state except CHECK.
- Illegal state encodings → IDLE on the next edge.

Optional Feature:
- Macro: MULT_SEQ_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any state other than IDLE → IDLE at the next edge, overriding all other transitions. done and err are not asserted for the aborted operation.
  - iter_cnt keeps the count reached.
  - abort in IDLE has no effect.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- Counter loaded 3, eqz driven from a datapath model, start pulse at edge 0 → lda/clrp in cycle 1, ldb cycle 2, ldp/decb in cycles 4, 6, 8; done first high in cycle 10; iter_cnt=3; P=3·A.
- Counter loaded 0 → done in cycle 4; zero ldp pulses; iter_cnt=0.
- MAX_ITER=4, eqz tied 0 → exactly 4 ADD pulses, then err=1 and done=1; held 5 cycles until ack → IDLE, err=0.
- start held high throughout plus extra start pulses during ADD → no extra lda/ldb; after ack, a new operation begins the cycle after IDLE.
- rst_n low asynchronously in the middle of an ADD cycle → outputs 0 immediately without waiting for clk; state IDLE; iter_cnt=0.
- With MULT_SEQ_CTRL_ABORT_EN, counter loaded 5, abort after 2 ADDs → IDLE next edge; done=0, err=0, iter_cnt=2.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Moore controller for a repeated-addition multiplier: sequences load/clear/add/decrement
// strobes, counts iterations, and aborts with err on a stuck counter. Optional: MULT_SEQ_CTRL_ABORT_EN.
module mult_seq_ctrl #(
    parameter int unsigned       ITER_W   = 16,
    parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(16'hFFFF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ack,
    input  logic              eqz,
`ifdef MULT_SEQ_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              lda,
    output logic              ldb,
    output logic              clrp,
    output logic              ldp,
    output logic              decb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        ADD    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ITER_W-1:0] r_iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = start ? LOAD_A : IDLE;
            LOAD_A:  w_next = LOAD_B;
            LOAD_B:  w_next = CHECK;
            CHECK: begin
                if (eqz) begin
                    w_next = DONE;
                end else if (r_iter == MAX_ITER) begin
                    w_next = ERR;
                end else begin
                    w_next = ADD;
                end
            end
            ADD:     w_next = CHECK;
            DONE:    w_next = ack ? IDLE : DONE;
            ERR:     w_next = ack ? IDLE : ERR;
            default: w_next = IDLE;
        endcase
`ifdef MULT_SEQ_CTRL_ABORT_EN
        if (abort && (r_state != IDLE)) begin
            w_next = IDLE;
        end
`endif
    end

    // Increment only when the ADD really completes, so an abort keeps the count reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter <= '0;
        end else if ((r_state == IDLE) && (w_next == LOAD_A)) begin
            r_iter <= '0;
        end else if ((r_state == ADD) && (w_next == CHECK)) begin
            r_iter <= r_iter + ITER_W'(1);
        end
    end

    always_comb begin
        lda  = 1'b0;
        ldb  = 1'b0;
        clrp = 1'b0;
        ldp  = 1'b0;
        decb = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (r_state)
            LOAD_A: begin
                lda  = 1'b1;
                clrp = 1'b1;
                busy = 1'b1;
            end
            LOAD_B: begin
                ldb  = 1'b1;
                busy = 1'b1;
            end
            CHECK:  busy = 1'b1;
            ADD: begin
                ldp  = 1'b1;
                decb = 1'b1;
                busy = 1'b1;
            end
            DONE:   done = 1'b1;
            ERR: begin
                err  = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign iter_cnt = r_iter;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a small datapath model plus a cycle-count
// reference derived from the operand value and the iteration limit.
module tb_mult_seq_ctrl;

    localparam int unsigned ITER_W = 16;
    localparam int          MAX    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        eqz;
`ifdef MULT_SEQ_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        lda, ldb, clrp, ldp, decb, busy, done, err;
    logic [15:0] iter_cnt;

    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;
    logic [15:0] dp_p = '0;

    int checks = 0;
    int errors = 0;

    mult_seq_ctrl #(
        .ITER_W   (ITER_W),
        .MAX_ITER (16'(MAX))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ack      (ack),
        .eqz      (eqz),
`ifdef MULT_SEQ_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .lda      (lda),
        .ldb      (ldb),
        .clrp     (clrp),
        .ldp      (ldp),
        .decb     (decb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    // Datapath model: A register, down-counting B, accumulator P.
    always @(posedge clk) begin
        if (lda)  dp_a <= op_a;
        if (ldb)  dp_b <= op_b;
        if (decb) dp_b <= dp_b - 16'd1;
        if (clrp) dp_p <= '0;
        if (ldp)  dp_p <= dp_p + dp_a;
    end
    assign eqz = (dp_b == 16'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int exp_iter);
        chk({tag, "_strobes"}, {lda, ldb, clrp, ldp, decb}, 5'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_iter"}, iter_cnt, exp_iter);
    endtask

    // One full operation: multiply a by n, stay in DONE/ERR for hold_n extra cycles, then ack.
    task automatic run_op(input logic [15:0] a, input int n, input bit hold, input int hold_n);
        int          k;
        bit          e;
        int          dc;
        logic [31:0] prod;
        k    = (n > MAX) ? MAX : n;
        e    = (n > MAX);
        dc   = 4 + 2 * k;
        prod = 32'(a) * 32'(k);
        op_a = a;
        op_b = 16'(n);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= dc + hold_n; c++) begin
            chk("lda",  lda,  c == 1);
            chk("clrp", clrp, c == 1);
            chk("ldb",  ldb,  c == 2);
            chk("ldp",  ldp,  (c >= 4) && (c <= 2 + 2 * k) && (c % 2 == 0));
            chk("decb", decb, (c >= 4) && (c <= 2 + 2 * k) && (c % 2 == 0));
            chk("busy", busy, c < dc);
            chk("done", done, c >= dc);
            chk("err",  err,  e && (c >= dc));
            if (c == dc) begin
                chk("iter_at_done", iter_cnt, k);
                if (!e) chk("product", dp_p, prod[15:0]);
            end
            if (!hold) start = 1'($urandom_range(0, 1));
            ack = (c < dc) ? 1'($urandom_range(0, 1)) : (c == dc + hold_n);
            tick();
        end
        chk_idle("after_ack", k);
        ack = 1'b0;
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #1;
        chk_idle("reset", 0);
        #6;
        rst_n = 1'b1;
        tick();
        chk_idle("idle", 0);

        run_op(16'h0007, 3, 1'b0, 0);
        run_op(16'h1234, 0, 1'b0, 2);
        run_op(16'h0005, 5, 1'b0, 5);
        chk_idle("err_cleared", MAX);
        run_op(16'h0003, MAX, 1'b0, 1);
        run_op(16'h0009, 2, 1'b1, 1);
        run_op(16'h000B, 1, 1'b1, 0);
        start = 1'b0;
        tick();
        chk_idle("idle_hold", 1);
        for (int i = 0; i < 10; i++) begin
            run_op(16'($urandom), int'($urandom_range(0, MAX + 3)), 1'b0,
                   int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of the second ADD cycle.
        op_a = 16'h0002;
        op_b = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_add", ldp, 1'b1);
        chk("pre_reset_iter", iter_cnt, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset", 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset", 0);

`ifdef MULT_SEQ_CTRL_ABORT_EN
        op_a = 16'h0004;
        op_b = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_abort_iter", iter_cnt, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort", 2);
        tick();
        chk_idle("abort_stays", 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort_in_idle", 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
